// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Purpose  : Holds the architectural PC and sequences instruction fetch for
//            the LEGv8 core. It keeps one request outstanding to instruction
//            memory, presents fetched words to decode with valid/stall, and
//            flushes/redirects on taken branches (including in-flight fetches).
// Ports    : CLK, Reset (async, active-high)
//            IMemReq/IMemAddr/IMemAck/IMemData : instruction memory handshake
//            Stall                             : decode back-pressure
//            Branch/ALUZero/Uncondbranch/BranchPC/SignExtImm64 : branch resolve
//            InstrValid/Instruction/InstrPC    : decode-side output
//            Redirect                          : one-cycle taken-branch pulse
//            CurrentPC                         : architectural PC register
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned IMM_SHIFT    = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        ALUZero,
  input  logic        Uncondbranch,
  input  logic [63:0] BranchPC,
  input  logic [63:0] SignExtImm64,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [63:0] InstrPC,
  output logic        Redirect,
  output logic [63:0] CurrentPC
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_FETCH = 2'd1;
  localparam logic [1:0] c_ST_HOLD  = 2'd2;
  localparam logic [1:0] c_ST_DRAIN = 2'd3;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [63:0] r_instr_pc;
  logic        r_redirect;

  logic        w_taken;
  logic [63:0] w_target;
  logic [63:0] w_seq_pc;
  logic        w_outstanding;

  assign w_taken  = (Branch & ALUZero) | Uncondbranch;
  // Both sums are 64-bit and wrap modulo 2^64 by construction.
  assign w_target = BranchPC + (SignExtImm64 << IMM_SHIFT);
  assign w_seq_pc = r_pc + 64'd4;

  // A request is still owed an ack in FETCH (issued) and DRAIN (abandoned).
  assign w_outstanding = (r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= c_ST_IDLE;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_instr_pc <= 64'h0;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      if ((r_state != c_ST_IDLE) && w_taken) begin
        // Flush wins over any ack this cycle; acked data is dropped. If the
        // request is still unanswered, wait out its ack before refetching.
        r_pc       <= w_target;
        r_valid    <= 1'b0;
        r_redirect <= 1'b1;
        r_state    <= (w_outstanding && !IMemAck) ? c_ST_DRAIN : c_ST_FETCH;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            r_state <= c_ST_FETCH;
          end
          c_ST_FETCH: begin
            if (IMemAck) begin
              r_instr    <= IMemData;
              r_instr_pc <= r_pc;
              r_valid    <= 1'b1;
              r_pc       <= w_seq_pc;
              r_state    <= Stall ? c_ST_HOLD : c_ST_FETCH;
            end else if (!Stall) begin
              // Decode consumed the presented word; nothing new arrived.
              r_valid <= 1'b0;
            end
          end
          c_ST_HOLD: begin
            if (!Stall) begin
              r_valid <= 1'b0;
              r_state <= c_ST_FETCH;
            end
          end
          c_ST_DRAIN: begin
            if (IMemAck) begin
              r_state <= c_ST_FETCH;
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
          end
        endcase
      end
    end
  end

  assign IMemReq     = (r_state == c_ST_FETCH);
  assign IMemAddr    = r_pc;
  assign CurrentPC   = r_pc;
  assign InstrValid  = r_valid;
  assign Instruction = r_instr;
  assign InstrPC     = r_instr_pc;
  assign Redirect    = r_redirect;

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the LEGv8 core.
- Selects the next PC internally: sequential PC+4, or branch target BranchPC + (SignExtImm64 << IMM_SHIFT) when a branch resolves taken.
- Drives a single-outstanding req/ack handshake to instruction memory and presents fetched instructions to decode with a valid/stall handshake.
- Flushes and redirects on taken branches, including a fetch that is still in flight.

Parameters:
RESET_VECTOR, 64'h0, PC loaded on reset.
IMM_SHIFT, 2, left shift applied to SignExtImm64 to form the byte offset.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-high reset.
IMemReq  output  1  fetch request to instruction memory.
IMemAddr  output  64  fetch address; equals CurrentPC while IMemReq=1.
IMemAck  input  1  memory has IMemData valid for the current request.
IMemData  input  32  instruction word; sampled only when IMemReq=1 and IMemAck=1.
Stall  input  1  decode cannot accept; holds the presented instruction.
Branch  input  1  conditional branch resolving this cycle.
ALUZero  input  1  branch condition (zero flag).
Uncondbranch  input  1  unconditional branch resolving this cycle.
BranchPC  input  64  PC of the resolving branch instruction.
SignExtImm64  input  64  sign-extended word offset of the resolving branch.
InstrValid  output  1  Instruction/InstrPC valid to decode.
Instruction  output  32  fetched instruction word.
InstrPC  output  64  address of Instruction.
Redirect  output  1  one-cycle pulse on the cycle after a taken branch is accepted.
CurrentPC  output  64  architectural PC register.

Behaviour:
- Taken = (Branch & ALUZero) | Uncondbranch. Target = BranchPC + (SignExtImm64 << IMM_SHIFT), modulo 2^64; overflow wraps silently.
- Sequential increment is CurrentPC + 4, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Reset (asynchronous, any state, including a fetch in flight):
  - state=IDLE; CurrentPC=RESET_VECTOR.
  - IMemReq=0, InstrValid=0, Instruction=0, InstrPC=0, Redirect=0.
  - Any ack arriving after reset deasserts is ignored unless IMemReq=1.
- IMemAddr is combinational from CurrentPC. IMemReq=1 only in FETCH.
- States and transitions (Taken is evaluated first, in every state except IDLE):
  - IDLE: next cycle -> FETCH.
  - FETCH: IMemReq held high, address stable, until IMemAck.
    - On ack with no Taken: Instruction<=IMemData, InstrPC<=CurrentPC, InstrValid<=1, CurrentPC<=CurrentPC+4.
    - After that ack: if Stall=1 -> HOLD, else remain FETCH (back-to-back, 1 instruction/cycle with zero-wait memory).
  - HOLD: IMemReq=0; Instruction, InstrPC and InstrValid frozen while Stall=1. When Stall=0 at the edge, InstrValid<=0 and -> FETCH.
  - DRAIN: IMemReq=0; waits for IMemAck of the abandoned request and discards its data, then -> FETCH.
- Taken handling (sampled at the edge):
  - CurrentPC<=Target; InstrValid<=0 (flush); Redirect<=1 for exactly one cycle.
  - If in FETCH and ack is not present that cycle -> DRAIN. Otherwise (ack present that cycle, or state HOLD) -> FETCH; the acked data is dropped.
  - Next IMemReq carries IMemAddr=Target: 1 cycle after the taken edge, or 1 cycle after the drain ack.
- Priority: Reset > Taken > IMemAck > Stall.
- Taken while Stall=1 still flushes; Stall only holds valid output.
- Consecutive Taken cycles: the last one wins; Redirect stays high.
- InstrValid is never 1 for an instruction fetched from a flushed path.

Test Plan:
- Reset released, RESET_VECTOR=0, IMemAck tied 1 -> IMemAddr 0,4,8,12 on consecutive cycles; InstrPC lags IMemAddr by one cycle; InstrValid=1 from cycle 2.
- Ack delayed 3 cycles at PC=0x10 -> IMemReq/IMemAddr=0x10 held 3 cycles; one instruction issued with InstrPC=0x10; next address 0x14.
- Stall=1 for 4 cycles with Instruction=0xD2800020 valid -> output frozen, IMemReq=0; on Stall=0 fetch resumes at InstrPC+4.
- Branch=1, ALUZero=1, BranchPC=0x40, SignExtImm64=-2 -> Redirect pulse, InstrValid=0, next IMemAddr=0x38. Repeat with ALUZero=0 -> sequential fetch, no Redirect.
- Uncondbranch=1 while a fetch waits for ack (target 0x100) -> DRAIN; late ack data not presented; then IMemAddr=0x100.
- Reset asserted mid-FETCH and mid-HOLD -> all outputs zero immediately, CurrentPC=RESET_VECTOR; PC 0xFFFF_FFFF_FFFF_FFFC sequential -> wraps to 0.
